cpu_control_unit: RTL and testbench

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_control_unit.sv | 155 +++++++++++++++
 tb/tb_cpu_control_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle CPU sequencer with memory-latency wait states, stall gating and retire counter
module cpu_control_unit #(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      instruction,
   input  logic [4:0]       flags,
   input  logic             stall,
   output logic             pc_en,
   output logic             reg_we,
   output logic             mem_we,
   output logic             ir_en,
   output logic             ls_cntl,
   output logic [1:0]       wb_sel,
   output logic [1:0]       pc_mux,
   output logic [3:0]       state_o,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC     = 4'd2,
      STORE    = 4'd3,
      LOAD_MEM = 4'd4,
      LOAD_WB  = 4'd5,
      BRANCH   = 4'd6,
      PC_INC   = 4'd7,
      JUMP     = 4'd8,
      JAL      = 4'd9
   } state_t;

   localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

   state_t           r_state, w_next;
   logic [3:0]       r_wait;
   logic [CNT_W-1:0] r_ret;
   logic [3:0]       w_op, w_ext;
   logic             w_last, w_cond, w_go;
   logic             w_pc, w_rw, w_mw, w_ir, w_done;

   assign w_op   = instruction[15:12];
   assign w_ext  = instruction[7:4];
   assign w_last = r_wait == LAST;
   assign w_go   = !stall && !rst;

   always_comb begin
      case (instruction[11:8])
         4'b0000: w_cond = flags[3];
         4'b0001: w_cond = !flags[3];
         4'b0010: w_cond = flags[0];
         4'b0011: w_cond = !flags[0];
         4'b0100: w_cond = flags[1];
         4'b0101: w_cond = !flags[1];
         4'b1100: w_cond = !flags[3] && flags[1];
         4'b1101: w_cond = flags[3] || !flags[1];
         4'b1110: w_cond = 1'b1;
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:    w_next = w_last ? DECODE : FETCH;
         DECODE: begin
            if (w_op == 4'b0100 && w_ext == 4'b0000)      w_next = LOAD_MEM;
            else if (w_op == 4'b0100 && w_ext == 4'b0100) w_next = STORE;
            else if (w_op == 4'b0100 && w_ext == 4'b1000) w_next = JAL;
            else if (w_op == 4'b0100 && w_ext == 4'b1100) w_next = w_cond ? JUMP : PC_INC;
            else if (w_op == 4'b1100)                     w_next = w_cond ? BRANCH : PC_INC;
            else                                          w_next = EXEC;
         end
         LOAD_MEM: w_next = w_last ? LOAD_WB : LOAD_MEM;
         default:  w_next = FETCH;
      endcase
   end

   always_comb begin
      w_pc    = 1'b0;
      w_rw    = 1'b0;
      w_mw    = 1'b0;
      w_ir    = 1'b0;
      w_done  = 1'b0;
      ls_cntl = 1'b1;
      wb_sel  = 2'b00;
      pc_mux  = 2'b00;
      case (r_state)
         FETCH:    w_ir = w_last;
         EXEC: begin
            w_rw   = 1'b1;
            w_pc   = 1'b1;
            w_done = 1'b1;
         end
         STORE: begin
            w_mw    = 1'b1;
            ls_cntl = 1'b0;
            w_pc    = 1'b1;
            w_done  = 1'b1;
         end
         LOAD_MEM: ls_cntl = 1'b0;
         LOAD_WB: begin
            w_rw   = 1'b1;
            wb_sel = 2'b01;
            w_pc   = 1'b1;
            w_done = 1'b1;
         end
         BRANCH: begin
            w_pc   = 1'b1;
            pc_mux = 2'b01;
            w_done = 1'b1;
         end
         PC_INC: begin
            w_pc   = 1'b1;
            w_done = 1'b1;
         end
         JUMP: begin
            w_pc   = 1'b1;
            pc_mux = 2'b10;
            w_done = 1'b1;
         end
         JAL: begin
            w_rw   = 1'b1;
            wb_sel = 2'b10;
            w_pc   = 1'b1;
            pc_mux = 2'b10;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   // stall and reset only mask the write strobes; mux selects keep the state's values
   assign pc_en      = w_pc && w_go;
   assign reg_we     = w_rw && w_go;
   assign mem_we     = w_mw && w_go;
   assign ir_en      = w_ir && w_go;
   assign instr_done = w_done && w_go;
   assign state_o    = r_state;
   assign retired    = r_ret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
         r_wait  <= 4'd0;
         r_ret   <= '0;
      end else if (!stall) begin
         r_state <= w_next;
         r_wait  <= (w_next != r_state) ? 4'd0 : r_wait + 4'd1;
         if (w_done) r_ret <= r_ret + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: random and directed checks of two sequencer instances against a per-instruction trace model
module tb_cpu_control_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ins0, ins1;
   logic [4:0]  fl0, fl1;
   logic        stl0, stl1;
   logic        pe0, rw0, mw0, ir0, ls0, dn0;
   logic        pe1, rw1, mw1, ir1, ls1, dn1;
   logic [1:0]  wb0, pm0, wb1, pm1;
   logic [3:0]  st0, st1;
   logic [1:0]  ret0;
   logic [15:0] ret1;
   logic [13:0] obs0, obs1;

   int checks = 0;
   int errors = 0;
   int exp_ret[2];
   int msk[2];

   localparam logic [13:0] SMSK = 14'h3C3E;

   always #5 clk = ~clk;

   cpu_control_unit #(.MEM_LAT(1), .CNT_W(2)) u0 (
      .clk(clk), .rst(rst), .instruction(ins0), .flags(fl0), .stall(stl0),
      .pc_en(pe0), .reg_we(rw0), .mem_we(mw0), .ir_en(ir0), .ls_cntl(ls0),
      .wb_sel(wb0), .pc_mux(pm0), .state_o(st0), .instr_done(dn0), .retired(ret0)
   );

   cpu_control_unit #(.MEM_LAT(3), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .instruction(ins1), .flags(fl1), .stall(stl1),
      .pc_en(pe1), .reg_we(rw1), .mem_we(mw1), .ir_en(ir1), .ls_cntl(ls1),
      .wb_sel(wb1), .pc_mux(pm1), .state_o(st1), .instr_done(dn1), .retired(ret1)
   );

   assign obs0 = {st0, pe0, rw0, mw0, ir0, ls0, wb0, pm0, dn0};
   assign obs1 = {st1, pe1, rw1, mw1, ir1, ls1, wb1, pm1, dn1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] e(input int s, input bit pc, input bit rw, input bit mw,
                                     input bit ir, input bit ls, input logic [1:0] wb,
                                     input logic [1:0] pm, input bit done);
      return {4'(s), pc, rw, mw, ir, ls, wb, pm, done};
   endfunction

   function automatic bit cond(input logic [3:0] code, input logic [4:0] f);
      bit z = f[3], c = f[0], l = f[1];
      case (code)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return l;
         4'h5: return !l;
         4'hC: return !z && l;
         4'hD: return z || !l;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] rnd_ins();
      logic [15:0] r = 16'($urandom);
      logic [3:0]  x = 4'($urandom_range(3)) << 2;
      case ($urandom_range(2))
         0: return r;
         1: return {4'h4, r[11:8], x, r[3:0]};
         default: return {4'hC, r[11:0]};
      endcase
   endfunction

   task automatic set_in(input int d, input logic [15:0] i, input logic [4:0] f, input logic s);
      if (d == 0) begin ins0 = i; fl0 = f; stl0 = s; end
      else begin ins1 = i; fl1 = f; stl1 = s; end
   endtask

   task automatic run(input int d, input logic [15:0] i, input logic [4:0] f, input int spct,
                      input logic [31:0] smask, input int abort_at, output int ncyc);
      logic [13:0] q[$];
      logic [13:0] ob, rw_w;
      logic [3:0]  op = i[15:12], ex = i[7:4];
      bit          c = cond(i[11:8], f);
      bit          s;
      int          lat = (d == 0) ? 1 : 3;
      rw_w = e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
      for (int k = 0; k < lat; k++) q.push_back(e(0, 0, 0, 0, k == lat - 1, 1, 2'b00, 2'b00, 0));
      q.push_back(e(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
      if (op == 4'h4 && ex == 4'h0) begin
         for (int k = 0; k < lat; k++) q.push_back(e(4, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
         q.push_back(e(5, 1, 1, 0, 0, 1, 2'b01, 2'b00, 1));
      end
      else if (op == 4'h4 && ex == 4'h4) q.push_back(e(3, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1));
      else if (op == 4'h4 && ex == 4'h8) q.push_back(e(9, 1, 1, 0, 0, 1, 2'b10, 2'b10, 1));
      else if (op == 4'h4 && ex == 4'hC)
         q.push_back(c ? e(8, 1, 0, 0, 0, 1, 2'b00, 2'b10, 1) : e(7, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1));
      else if (op == 4'hC)
         q.push_back(c ? e(6, 1, 0, 0, 0, 1, 2'b00, 2'b01, 1) : e(7, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1));
      else q.push_back(e(2, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
      ncyc = 0;
      while (q.size() > 0) begin
         s = ncyc < 100 && ((ncyc < 32 && smask[ncyc]) || ($urandom_range(99) < spct));
         set_in(d, i, f, s);
         @(negedge clk);
         ob = (d == 0) ? obs0 : obs1;
         chk("out", 32'(ob), 32'(s ? (q[0] & SMSK) : q[0]));
         chk("ret", (d == 0) ? 32'(ret0) : 32'(ret1), 32'(exp_ret[d]));
         if (ncyc == abort_at) begin
            #2 rst = 1'b1;
            #1;
            ob = (d == 0) ? obs0 : obs1;
            chk("arst_state", 32'(ob[13:10]), 0);
            chk("arst_word", 32'(ob), 32'(rw_w));
            @(posedge clk);
            #1;
            ob = (d == 0) ? obs0 : obs1;
            chk("rst_hold", 32'(ob), 32'(rw_w));
            chk("rst_ret", 32'(ret1), 0);
            rst = 1'b0;
            exp_ret[0] = 0;
            exp_ret[1] = 0;
            q.delete();
            ncyc++;
         end
         else begin
            @(posedge clk);
            #1;
            ncyc++;
            if (!s) begin
               if (q[0][0]) exp_ret[d] = (exp_ret[d] + 1) & msk[d];
               void'(q.pop_front());
            end
         end
      end
      set_in(d, i, f, 1'b1);
   endtask

   initial begin
      int n;
      msk[0] = 3;
      msk[1] = 16'hFFFF;
      exp_ret[0] = 0;
      exp_ret[1] = 0;
      rst = 1'b1;
      set_in(0, 16'h0, 5'h0, 1'b0);
      set_in(1, 16'h0, 5'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst0", 32'(obs0), 32'(e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0)));
      chk("rst1", 32'(obs1), 32'(e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0)));
      chk("rst_ret0", 32'(ret0), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      set_in(0, 16'h0, 5'h0, 1'b1);
      set_in(1, 16'h0, 5'h0, 1'b1);

      run(0, 16'h0105, 5'h00, 0, 0, -1, n);
      chk("rtype_cyc", n, 3);
      chk("rtype_ret", 32'(ret0), 1);
      run(0, 16'h4102, 5'h00, 0, 0, -1, n);
      chk("load1_cyc", n, 4);
      run(0, 16'hC005, 5'b01000, 0, 0, -1, n);
      run(0, 16'hC005, 5'b00000, 0, 0, -1, n);
      run(0, 16'hCE05, 5'($urandom), 0, 0, -1, n);
      run(0, 16'h4483, 5'h00, 0, 0, -1, n);
      run(0, 16'h4EC3, 5'h00, 0, 0, -1, n);
      run(0, 16'h4FC3, 5'h1F, 0, 0, -1, n);

      run(1, 16'h4102, 5'h00, 0, 0, -1, n);
      chk("load3_cyc", n, 8);
      run(1, 16'h4102, 5'h00, 0, 32'h0000_03E0, -1, n);
      chk("stall_cyc", n, 13);
      for (int k = 0; k < 20; k++) run(1, rnd_ins(), 5'($urandom), 25, 0, -1, n);
      run(1, 16'h4102, 5'h00, 0, 0, 5, n);

      for (int k = 0; k < 4; k++) run(0, rnd_ins(), 5'($urandom), 0, 0, -1, n);
      chk("wrap", 32'(ret0), 0);
      for (int k = 0; k < 20; k++) run(0, rnd_ins(), 5'($urandom), 25, 0, -1, n);
      for (int k = 0; k < 10; k++) run(1, rnd_ins(), 5'($urandom), 0, 0, -1, n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
